norm_sched: RTL and testbench

- Round-robin scheduler that shares one `normalizer` instance among NREQ accumulator requesters, such as conv/FC channel lanes.
- Holds the layer's shift selection (`sel`) as a configuration register and drives the external normalizer's `in`/`sel` pins.
- Captures the normalizer's 8-bit result into a one-entry output register with a valid/ready handshake.
- Sits between the MAC accumulators and the activation buffer, and is configured per layer by the RISC CPU.

---
 rtl/norm_sched.sv | 144 ++++++++++++++
 tb/tb_norm_sched.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/norm_sched.sv
// norm_sched - round-robin scheduler sharing one normalizer among NREQ
// accumulator requesters. Holds the layer's shift select, drives the
// external normalizer's in/sel pins and captures its result into a
// one-entry output register with a valid/ready handshake.
//
// Build option: NORM_SCHED_RELU_EN - when defined, negative normalized
// results are clamped to zero as they are captured (ReLU).
//
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   cfg_we, cfg_sel        config write strobe / shift select (3 = disabled)
//   cfg_err                one-cycle pulse when a config write is rejected
//   req_valid, req_data    per-requester valid and packed 2*BIT accumulators
//   req_ready              per-requester ready, one-hot or zero
//   norm_in, norm_sel      to the normalizer
//   norm_out, norm_valid   from the normalizer
//   res_valid, res_data,
//   res_id, res_ready      result handshake and producing requester id
//   busy                   result pending or request waiting while enabled
//
// state    | meaning
// ---------+---------------------------------------------
// ST_DIS   | act_sel == 3, requests are held off
// ST_EMPTY | enabled, output register empty
// ST_FULL  | enabled, output register holds a result

module norm_sched #(
    parameter int BIT  = 8,
    parameter int NREQ = 4,
    parameter int ID_W = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cfg_we,
    input  logic [1:0]            cfg_sel,
    output logic                  cfg_err,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*2*BIT-1:0] req_data,
    output logic [NREQ-1:0]       req_ready,
    output logic [2*BIT-1:0]      norm_in,
    output logic [1:0]            norm_sel,
    input  logic [BIT-1:0]        norm_out,
    input  logic                  norm_valid,
    output logic                  res_valid,
    output logic [BIT-1:0]        res_data,
    output logic [ID_W-1:0]       res_id,
    input  logic                  res_ready,
    output logic                  busy
);

    typedef enum logic [1:0] {ST_DIS, ST_EMPTY, ST_FULL} state_t;

    logic [1:0]      act_sel;
    logic [ID_W-1:0] rr_ptr;
    state_t          state;
    logic            grant_found;
    logic [ID_W-1:0] grant_id;
    logic [ID_W:0]   idx;
    logic [ID_W-1:0] rr_next;
    logic            can_take;
    logic            accept;
    logic [BIT-1:0]  captured;
    logic [2*BIT-1:0] req_acc [NREQ];

    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
        assign req_acc[i] = req_data[i*2*BIT +: 2*BIT];
    end

    always_comb begin
        if (act_sel == 2'd3)
            state = ST_DIS;
        else if (res_valid)
            state = ST_FULL;
        else
            state = ST_EMPTY;
    end

    // Search starts at rr_ptr and wraps; idx has one spare bit so the
    // wrap works for NREQ that is not a power of two.
    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
        idx         = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = {1'b0, rr_ptr} + (ID_W+1)'(k);
            if (idx >= (ID_W+1)'(NREQ))
                idx = idx - (ID_W+1)'(NREQ);
            if (!grant_found && req_valid[idx[ID_W-1:0]]) begin
                grant_found = 1'b1;
                grant_id    = idx[ID_W-1:0];
            end
        end
    end

    assign rr_next  = (grant_id == ID_W'(NREQ-1)) ? '0 : grant_id + 1'b1;
    assign norm_in  = grant_found ? req_acc[grant_id] : '0;
    assign norm_sel = act_sel;

    // A full register can take a new result only in the cycle it drains.
    assign can_take = ((state == ST_EMPTY) || (state == ST_FULL && res_ready))
                      && norm_valid && !cfg_we;

    always_comb begin
        req_ready = '0;
        if (can_take && grant_found)
            req_ready[grant_id] = 1'b1;
    end

    assign accept = |(req_valid & req_ready);
    assign busy   = res_valid || ((state != ST_DIS) && (|req_valid));

`ifdef NORM_SCHED_RELU_EN
    assign captured = norm_out[BIT-1] ? '0 : norm_out;
`else
    assign captured = norm_out;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            act_sel   <= 2'd3;
            rr_ptr    <= '0;
            res_valid <= 1'b0;
            res_data  <= '0;
            res_id    <= '0;
            cfg_err   <= 1'b0;
        end else begin
            // Changing the shift under a pending result would make the
            // held value ambiguous, so such writes are refused.
            cfg_err <= cfg_we && res_valid;
            if (cfg_we && !res_valid)
                act_sel <= cfg_sel;

            if (accept) begin
                res_valid <= 1'b1;
                res_data  <= captured;
                res_id    <= grant_id;
                rr_ptr    <= rr_next;
            end else if (res_valid && res_ready) begin
                res_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_norm_sched.sv
// Self-checking bench for norm_sched: a behavioural normalizer, a small
// reference model of the scheduler, and a result scoreboard queue.
module tb_norm_sched;

    localparam int BIT  = 8;
    localparam int NREQ = 4;
    localparam int ID_W = 2;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  cfg_we;
    logic [1:0]            cfg_sel;
    logic                  cfg_err;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ*2*BIT-1:0] req_data;
    logic [NREQ-1:0]       req_ready;
    logic [2*BIT-1:0]      norm_in;
    logic [1:0]            norm_sel;
    logic [BIT-1:0]        norm_out;
    logic                  norm_valid;
    logic                  res_valid;
    logic [BIT-1:0]        res_data;
    logic [ID_W-1:0]       res_id;
    logic                  res_ready;
    logic                  busy;

    norm_sched #(.BIT(BIT), .NREQ(NREQ), .ID_W(ID_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_we     (cfg_we),
        .cfg_sel    (cfg_sel),
        .cfg_err    (cfg_err),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .norm_in    (norm_in),
        .norm_sel   (norm_sel),
        .norm_out   (norm_out),
        .norm_valid (norm_valid),
        .res_valid  (res_valid),
        .res_data   (res_data),
        .res_id     (res_id),
        .res_ready  (res_ready),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // External normalizer: arithmetic shift right by 10/9/8, low BIT bits.
    function automatic logic [BIT-1:0] norm_fn(input logic [2*BIT-1:0] x,
                                               input logic [1:0] s);
        logic signed [2*BIT-1:0] v;
        int sh;
        sh = 10 - int'(s);
        v = $signed(x) >>> sh;
        return v[BIT-1:0];
    endfunction

    assign norm_out = norm_fn(norm_in, norm_sel);

    function automatic logic [BIT-1:0] exp_res(input logic [2*BIT-1:0] x,
                                               input logic [1:0] s);
        logic [BIT-1:0] r;
        r = norm_fn(x, s);
`ifdef NORM_SCHED_RELU_EN
        if (r[BIT-1]) r = '0;
`endif
        return r;
    endfunction

    function automatic int rr_pick(input logic [NREQ-1:0] v, input int ptr);
        for (int k = 0; k < NREQ; k++)
            if (v[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
        return -1;
    endfunction

    typedef struct packed {
        logic [ID_W-1:0] id;
        logic [BIT-1:0]  data;
    } exp_t;

    exp_t sb[$];

    int n_assert = 0;
    int n_fail   = 0;

    logic [1:0]      m_sel;
    int              m_ptr;
    logic            m_rv;
    logic [BIT-1:0]  m_data;
    logic [ID_W-1:0] m_id;
    logic            m_err;
    logic            hold_valid;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic set_req(input int i, input logic [2*BIT-1:0] d);
        req_data[i*2*BIT +: 2*BIT] = d;
        req_valid[i] = 1'b1;
    endtask

    // One clock: check combinational outputs at the negedge against the
    // model, push any expected accept, then check registers after the edge.
    task automatic cycle();
        int             g;
        logic           take;
        logic           acc;
        logic [NREQ-1:0] er;
        exp_t           e;
        @(negedge clk);
        g    = rr_pick(req_valid, m_ptr);
        take = (m_sel != 2'd3) && norm_valid && (!m_rv || res_ready) && !cfg_we;
        er   = '0;
        if (take && g >= 0) er[g] = 1'b1;
        chk("req_ready", 32'(req_ready), 32'(er));
        chk("busy", 32'(busy), 32'(m_rv || ((m_sel != 2'd3) && (|req_valid))));
        chk("norm_sel", 32'(norm_sel), 32'(m_sel));
        if (g >= 0) chk("norm_in", 32'(norm_in), 32'(req_data[g*2*BIT +: 2*BIT]));
        acc = take && (g >= 0) && !rst;
        if (acc) begin
            e.id   = ID_W'(g);
            e.data = exp_res(req_data[g*2*BIT +: 2*BIT], m_sel);
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        if (rst) begin
            m_sel = 2'd3; m_ptr = 0; m_rv = 1'b0; m_data = '0; m_id = '0; m_err = 1'b0;
            sb.delete();
            chk("rst_res_data", 32'(res_data), 32'h0);
            chk("rst_res_id", 32'(res_id), 32'h0);
        end else begin
            m_err = cfg_we && m_rv;
            if (cfg_we && !m_rv) m_sel = cfg_sel;
            if (acc) begin
                m_rv  = 1'b1;
                m_ptr = (g + 1) % NREQ;
                if (!hold_valid) req_valid[g] = 1'b0;
                e = sb.pop_front();
                m_data = e.data;
                m_id   = e.id;
                chk("res_data", 32'(res_data), 32'(e.data));
                chk("res_id", 32'(res_id), 32'(e.id));
            end else if (m_rv && res_ready) begin
                m_rv = 1'b0;
            end
        end
        chk("res_valid", 32'(res_valid), 32'(m_rv));
        chk("cfg_err", 32'(cfg_err), 32'(m_err));
        if (m_rv) begin
            chk("res_data_hold", 32'(res_data), 32'(m_data));
            chk("res_id_hold", 32'(res_id), 32'(m_id));
        end
    endtask

    task automatic cfg_write(input logic [1:0] s);
        cfg_we  = 1'b1;
        cfg_sel = s;
        cycle();
        cfg_we  = 1'b0;
    endtask

    initial begin
        rst = 1'b1; cfg_we = 1'b0; cfg_sel = 2'd0;
        req_valid = '0; req_data = '0;
        norm_valid = 1'b1; res_ready = 1'b1; hold_valid = 1'b0;
        m_sel = 2'd3; m_ptr = 0; m_rv = 1'b0; m_data = '0; m_id = '0; m_err = 1'b0;
        cycle();
        cycle();
        rst = 1'b0;

        // Reset state
        chk("reset_res_valid", 32'(res_valid), 32'h0);
        chk("reset_cfg_err", 32'(cfg_err), 32'h0);
        chk("reset_norm_sel", 32'(norm_sel), 32'h3);
        chk("reset_req_ready", 32'(req_ready), 32'h0);

        // Requests before config are held off
        set_req(0, 16'h0C00);
        cycle();
        cycle();
        cfg_write(2'd0);
        chk("sel_after_cfg", 32'(norm_sel), 32'h0);

        // 0x0C00 >>> 10 = 3
        cycle();
        chk("req0_data", 32'(res_data), 32'h03);
        chk("req0_id", 32'(res_id), 32'h0);

        // 0xFC00 >>> 10 = -1
        set_req(1, 16'hFC00);
        cycle();
`ifdef NORM_SCHED_RELU_EN
        chk("req1_neg", 32'(res_data), 32'h00);
`else
        chk("req1_neg", 32'(res_data), 32'hFF);
`endif
        cycle();
        cfg_write(2'd2);

        // 0x7FFF >>> 8 = 0x7F; requester 3 so the pointer wraps to 0
        set_req(3, 16'h7FFF);
        cycle();
        chk("req3_sel2", 32'(res_data), 32'h7F);
        chk("req3_id", 32'(res_id), 32'h3);

        // Continuous round robin: 0,1,2,3,0
        hold_valid = 1'b1;
        set_req(0, 16'h1234);
        set_req(1, 16'h8100);
        set_req(2, 16'h0500);
        set_req(3, 16'hFF00);
        for (int k = 0; k < 5; k++) begin
            cycle();
            chk("rr_order", 32'(res_id), 32'(k % NREQ));
        end

        // Stall then release (drain + accept in one cycle)
        res_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cycle();
            chk("stall_ready", 32'(req_ready), 32'h0);
        end
        res_ready = 1'b1;
        cycle();
        chk("release_id", 32'(res_id), 32'h1);
        hold_valid = 1'b0;
        req_valid  = '0;
        cycle();

        // Rejected config write while a result is pending
        res_ready = 1'b0;
        set_req(2, 16'h0300);
        cycle();
        cfg_write(2'd1);
        chk("cfg_err_pulse", 32'(cfg_err), 32'h1);
        chk("sel_unchanged", 32'(norm_sel), 32'h2);
        cycle();
        res_ready = 1'b1;
        cycle();

        // Disable, requests refused
        cfg_write(2'd3);
        set_req(1, 16'h0400);
        cycle();
        cycle();
        chk("dis_ready", 32'(req_ready), 32'h0);

        // Enable; normalizer not valid blocks accepts
        cfg_write(2'd0);
        norm_valid = 1'b0;
        cycle();
        norm_valid = 1'b1;
        cycle();

        // Reset with a pending result
        res_ready = 1'b0;
        set_req(3, 16'h2000);
        cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        req_valid = '0;
        chk("rst_mid_valid", 32'(res_valid), 32'h0);
        chk("rst_mid_sel", 32'(norm_sel), 32'h3);
        cycle();

        chk("sb_empty", 32'(sb.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
